fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_fetch_stage.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: pipeline controls and targets in, instruction-memory port and F/D buffer fields out.
// The slave modport is the fetch stage; the master modport is the control/decode side.
interface fetch_stage_if #(
   parameter int unsigned PC_W = 32
);
   logic            pc_enable;
   logic            f_d_buffer_enable;
   logic            flush;
   logic [1:0]      jump_sel;
   logic [PC_W-1:0] branch_target;
   logic [PC_W-1:0] mem_target;
   logic [15:0]     imem_data;
   logic [PC_W-1:0] imem_addr;
   logic [5:0]      opcode;
   logic [2:0]      src;
   logic [2:0]      dst;
   logic [15:0]     imm;
   logic [PC_W-1:0] pc_next_out;
   logic            fd_valid;

   modport master (
      output pc_enable, f_d_buffer_enable, flush, jump_sel, branch_target, mem_target, imem_data,
      input  imem_addr, opcode, src, dst, imm, pc_next_out, fd_valid
   );

   modport slave (
      input  pc_enable, f_d_buffer_enable, flush, jump_sel, branch_target, mem_target, imem_data,
      output imem_addr, opcode, src, dst, imm, pc_next_out, fd_valid
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select and F/D pipeline buffer.
// Define FETCH_IMM_EN to enable two-word instructions (bit 0 = immediate word follows).
module fetch_stage #(
   parameter int unsigned     PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
   parameter logic [PC_W-1:0] INT_VEC  = 32'h0000_0002
) (
   input logic          clk,
   input logic          rst,
   fetch_stage_if.slave bus
);

`ifdef FETCH_IMM_EN
   localparam logic [0:0] S_FETCH = 1'b0;
   localparam logic [0:0] S_IMM   = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [15:0] hold_q, hold_d;
`endif

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pc_plus1, pc_sel;
   logic [5:0]      opcode_q, opcode_d;
   logic [2:0]      src_q, src_d;
   logic [2:0]      dst_q, dst_d;
   logic [15:0]     imm_q, imm_d;
   logic [PC_W-1:0] pcn_q, pcn_d;
   logic            valid_q, valid_d;
   logic            do_load, do_bubble;
   logic [15:0]     load_word, load_imm;
   logic            unused_low_bits;

   // Next-PC selection; all-ones wraps to zero on the sequential path.
   always_comb begin
      pc_plus1 = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      case (bus.jump_sel)
         2'b00:   pc_sel = pc_plus1;
         2'b01:   pc_sel = bus.branch_target;
         2'b10:   pc_sel = bus.mem_target;
         2'b11:   pc_sel = INT_VEC;
         default: pc_sel = pc_plus1;
      endcase
      if (bus.pc_enable) pc_d = pc_sel;
      else               pc_d = pc_q;
   end

   // Decide whether the buffer takes a bubble, a new instruction, or holds.
   always_comb begin
      load_word = bus.imem_data;
      load_imm  = 16'h0000;
      do_load   = 1'b0;
      do_bubble = 1'b0;
`ifdef FETCH_IMM_EN
      state_d   = state_q;
      hold_d    = hold_q;
      if (bus.flush) begin
         do_bubble = 1'b1;
         state_d   = S_FETCH;
         hold_d    = 16'h0000;
      end else if (bus.pc_enable) begin
         case (state_q)
            S_FETCH: begin
               if (bus.imem_data[0]) begin
                  hold_d    = bus.imem_data;
                  state_d   = S_IMM;
                  do_bubble = bus.f_d_buffer_enable;
               end else begin
                  do_load   = bus.f_d_buffer_enable;
               end
            end
            S_IMM: begin
               // A redirect here means the immediate word is never fetched: drop the pending opcode.
               state_d = S_FETCH;
               hold_d  = 16'h0000;
               if (bus.jump_sel != 2'b00) begin
                  do_bubble = bus.f_d_buffer_enable;
               end else begin
                  do_load   = bus.f_d_buffer_enable;
                  load_word = hold_q;
                  load_imm  = bus.imem_data;
               end
            end
            default: state_d = S_FETCH;
         endcase
      end else begin
         state_d = state_q;
      end
`else
      if (bus.flush)          do_bubble = 1'b1;
      else if (bus.pc_enable) do_load   = bus.f_d_buffer_enable;
      else                    do_load   = 1'b0;
`endif
   end

   // F/D buffer next values.
   always_comb begin
      if (do_bubble) begin
         opcode_d = 6'b000000;
         src_d    = 3'b000;
         dst_d    = 3'b000;
         imm_d    = 16'h0000;
         pcn_d    = {PC_W{1'b0}};
         valid_d  = 1'b0;
      end else if (do_load) begin
         opcode_d = load_word[15:10];
         src_d    = load_word[9:7];
         dst_d    = load_word[6:4];
         imm_d    = load_imm;
         pcn_d    = pc_plus1;
         valid_d  = 1'b1;
      end else begin
         opcode_d = opcode_q;
         src_d    = src_q;
         dst_d    = dst_q;
         imm_d    = imm_q;
         pcn_d    = pcn_q;
         valid_d  = valid_q;
      end
   end

   assign unused_low_bits = ^load_word[3:0];

   // State registers; reset yields a bubble at RESET_PC in FETCH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= RESET_PC;
         opcode_q <= 6'b000000;
         src_q    <= 3'b000;
         dst_q    <= 3'b000;
         imm_q    <= 16'h0000;
         pcn_q    <= {PC_W{1'b0}};
         valid_q  <= 1'b0;
`ifdef FETCH_IMM_EN
         state_q  <= S_FETCH;
         hold_q   <= 16'h0000;
`endif
      end else begin
         pc_q     <= pc_d;
         opcode_q <= opcode_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         imm_q    <= imm_d;
         pcn_q    <= pcn_d;
         valid_q  <= valid_d;
`ifdef FETCH_IMM_EN
         state_q  <= state_d;
         hold_q   <= hold_d;
`endif
      end
   end

   assign bus.imem_addr   = pc_q;
   assign bus.opcode      = opcode_q;
   assign bus.src         = src_q;
   assign bus.dst         = dst_q;
   assign bus.imm         = imm_q;
   assign bus.pc_next_out = pcn_q;
   assign bus.fd_valid    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random control traffic
// checked against a behavioural model of the fetch rules.
module tb_fetch_stage;
   localparam int unsigned PC_W = 32;
`ifdef FETCH_IMM_EN
   localparam bit IMM_EN = 1'b1;
`else
   localparam bit IMM_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   fetch_stage_if #(.PC_W(PC_W)) bus ();

   fetch_stage #(.PC_W(PC_W), .RESET_PC(32'h0000_0000), .INT_VEC(32'h0000_0002)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] imem [256];
   always_comb bus.imem_data = imem[bus.imem_addr[7:0]];

   int tests = 0;
   int fails = 0;

   // Reference model: architectural PC, "waiting for immediate" flag, held opcode word, expected buffer.
   logic [31:0] m_pc;
   bit          m_pending;
   logic [15:0] m_hold;
   logic [5:0]  e_op;
   logic [2:0]  e_src, e_dst;
   logic [15:0] e_imm;
   logic [31:0] e_pcn;
   logic        e_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("imem_addr",   bus.imem_addr,          m_pc);
      chk("opcode",      {26'd0, bus.opcode},    {26'd0, e_op});
      chk("src",         {29'd0, bus.src},       {29'd0, e_src});
      chk("dst",         {29'd0, bus.dst},       {29'd0, e_dst});
      chk("imm",         {16'd0, bus.imm},       {16'd0, e_imm});
      chk("pc_next_out", bus.pc_next_out,        e_pcn);
      chk("fd_valid",    {31'd0, bus.fd_valid},  {31'd0, e_valid});
   endtask

   task automatic model_reset();
      m_pc = 32'h0000_0000; m_pending = 1'b0; m_hold = 16'h0000;
      e_op = 6'd0; e_src = 3'd0; e_dst = 3'd0; e_imm = 16'h0000; e_pcn = 32'd0; e_valid = 1'b0;
   endtask

   task automatic model_bubble();
      e_op = 6'd0; e_src = 3'd0; e_dst = 3'd0; e_imm = 16'h0000; e_pcn = 32'd0; e_valid = 1'b0;
   endtask

   task automatic model_load(input logic [15:0] w, input logic [15:0] immw);
      e_op = w[15:10]; e_src = w[9:7]; e_dst = w[6:4]; e_imm = immw;
      e_pcn = m_pc + 32'd1; e_valid = 1'b1;
   endtask

   // One clock edge of the fetch rules, using the model's own copy of memory.
   task automatic model_edge();
      logic [15:0] w;
      logic [31:0] tgt;
      w = imem[m_pc[7:0]];
      case (bus.jump_sel)
         2'b00:   tgt = m_pc + 32'd1;
         2'b01:   tgt = bus.branch_target;
         2'b10:   tgt = bus.mem_target;
         default: tgt = 32'h0000_0002;
      endcase
      if (bus.flush) begin
         model_bubble();
         m_pending = 1'b0;
      end else if (bus.pc_enable) begin
         if (!m_pending) begin
            if (IMM_EN && w[0]) begin
               m_hold = w; m_pending = 1'b1;
               if (bus.f_d_buffer_enable) model_bubble();
            end else if (bus.f_d_buffer_enable) begin
               model_load(w, 16'h0000);
            end
         end else begin
            m_pending = 1'b0;
            if (bus.jump_sel != 2'b00) begin
               if (bus.f_d_buffer_enable) model_bubble();
            end else if (bus.f_d_buffer_enable) begin
               model_load(m_hold, w);
            end
         end
      end
      if (bus.pc_enable) m_pc = tgt;
   endtask

   task automatic drive(input bit pe, input bit be, input bit fl, input logic [1:0] js,
                        input logic [31:0] bt, input logic [31:0] mt);
      bus.pc_enable = pe; bus.f_d_buffer_enable = be; bus.flush = fl;
      bus.jump_sel = js; bus.branch_target = bt; bus.mem_target = mt;
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
      imem[0]  = 16'h8A50;
      for (int i = 1; i < 4; i++) imem[i] = 16'($urandom) & 16'hFFFE;
      imem[4]  = 16'h0C31;
      imem[5]  = 16'h1234;
      imem[6]  = 16'h0C35;
      imem[64] = 16'h4A20;

      bus.pc_enable = 1'b0; bus.f_d_buffer_enable = 1'b0; bus.flush = 1'b0;
      bus.jump_sel = 2'b00; bus.branch_target = 32'd0; bus.mem_target = 32'd0;
      rst = 1'b0;
      model_reset();
      #2;
      check_all();
      @(posedge clk); @(posedge clk); #1;
      check_all();
      rst = 1'b1;

      // First fetch from RESET_PC, one-word instruction.
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
      chk("r038_opcode", {26'd0, bus.opcode}, {26'd0, 6'b100010});
      chk("r038_src",    {29'd0, bus.src},    {29'd0, 3'b100});
      chk("r038_dst",    {29'd0, bus.dst},    {29'd0, 3'b101});
      chk("r038_pcn",    bus.pc_next_out,     32'd1);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);

      // Two-word instruction at 4/5.
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
`ifdef FETCH_IMM_EN
      chk("r039_bubble", {31'd0, bus.fd_valid}, 32'd0);
`endif
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
`ifdef FETCH_IMM_EN
      chk("r039_opcode", {26'd0, bus.opcode}, {26'd0, 6'b000011});
      chk("r039_imm",    {16'd0, bus.imm},    32'h0000_1234);
      chk("r039_pcn",    bus.pc_next_out,     32'd6);
      chk("r039_pc",     bus.imem_addr,       32'd6);
`endif

      // Full stall for three cycles, regardless of jump_sel.
      for (int i = 0; i < 3; i++)
         drive(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 32'($urandom), 32'($urandom));

      // Enter IMM at address 6, then redirect with flush.
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
      drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h0000_0040, 32'd0);
      chk("r041_valid", {31'd0, bus.fd_valid}, 32'd0);
      chk("r041_addr",  bus.imem_addr,         32'h0000_0040);
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
      chk("r041_fetch", {31'd0, bus.fd_valid}, 32'd1);

      // PC wrap and interrupt vector.
      drive(1'b1, 1'b1, 1'b1, 2'b10, 32'd0, 32'hFFFF_FFFF);
      chk("r042_max",  bus.imem_addr, 32'hFFFF_FFFF);
      drive(1'b1, 1'b1, 1'b1, 2'b00, 32'd0, 32'd0);
      chk("r042_wrap", bus.imem_addr, 32'h0000_0000);
      drive(1'b1, 1'b1, 1'b0, 2'b11, 32'd0, 32'd0);
      chk("r042_int",  bus.imem_addr, 32'h0000_0002);

      // Random control traffic.
      for (int i = 0; i < 300; i++) begin
         logic [1:0] js;
         logic [31:0] bt, mt;
         js = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
         bt = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
         mt = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
               js, bt, mt);
      end

      // Asynchronous reset in the middle of a two-word instruction.
      drive(1'b1, 1'b1, 1'b1, 2'b01, 32'd6, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("r043_valid", {31'd0, bus.fd_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
      chk("r043_refetch", {26'd0, bus.opcode}, {26'd0, 6'b100010});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
